// File: rtl/vic_irq_arbiter.sv
// rtl/vic_irq_arbiter.sv - interrupt front-end: sync, edge latch, enable mask, priority grant
// Single in-service tracking with tail-chaining on return-from-interrupt.
module vic_irq_arbiter #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] i_irq_lines,
  input  logic [N_SRC-1:0] i_edge_cfg,
  input  logic             i_en_we,
  input  logic [N_SRC-1:0] i_en_data,
  input  logic             i_reti,
  output logic             o_IRQ,
  output logic [4:0]       o_ISR_addr,
  output logic [N_SRC-1:0] o_pending,
  output logic [N_SRC-1:0] o_en,
  output logic             o_in_service
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_SERVICE} state_t;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] r_sync;
  logic [N_SRC-1:0] r_hist;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_en;
  logic [4:0]       r_addr;
  state_t           r_state;

  logic [N_SRC-1:0] w_sync;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [4:0]       w_winner;
  logic             w_any;
  logic             w_load;
  state_t           w_state_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_hist;
  assign w_elig = r_pend & r_en;
  assign w_any  = |w_elig;

  always_comb begin
    w_winner = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_elig[k]) w_winner = 5'(k);
    end
  end

  // The granted edge source is consumed in GRANT; a coincident new edge re-arms it.
  always_comb begin
    w_clr = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_clr[k] = (r_state == ST_GRANT) && (r_addr == 5'(k)) && i_edge_cfg[k];
    end
  end

  assign w_pend_nxt = (i_edge_cfg & ((r_pend & ~w_clr) | w_rise)) | (~i_edge_cfg & w_sync);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_load      = 1'b1;
        end
      end
      ST_GRANT: w_state_nxt = ST_SERVICE;
      ST_SERVICE: begin
        if (i_reti) begin
          if (w_any) begin
            w_state_nxt = ST_GRANT;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_hist  <= '0;
      r_pend  <= '0;
      r_en    <= '0;
      r_addr  <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_irq_lines};
      r_hist  <= w_sync;
      r_pend  <= w_pend_nxt;
      r_state <= w_state_nxt;
      if (i_en_we) r_en <= i_en_data;
      if (w_load) r_addr <= w_winner;
    end
  end

  assign o_IRQ        = (r_state == ST_GRANT);
  assign o_in_service = (r_state == ST_SERVICE);
  assign o_ISR_addr   = r_addr;
  assign o_pending    = r_pend;
  assign o_en         = r_en;

endmodule
